uart_rx: RTL and testbench

- Serial UART receiver that sits directly upstream of the TDC capture stage.
- Deserialises the asynchronous rx line (8N1, LSB first) into bytes and drives the `uart_data` bus that the TDC delay line consumes.
- Flags each byte with a one-cycle `data_valid` strobe and reports framing errors.
- Purely synchronous; one clock domain.

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-flop synchronised rx line, mid-bit sampling,
// one-cycle valid / framing-error strobes and a break-hold state.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [7:0]    data_q;
    logic          dv_q;
    logic          fe_q;
    logic          busy_q;

    // Shift register with the current sample inserted at the bit index
    always_comb begin
        shift_d            = shift_q;
        shift_d[bit_idx_q] = rx_s_q;
    end

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM with registered strobes and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            fe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            dv_q    <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BRK: begin
                    // A held-low line must go high before a new start is accepted
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= BRK;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_data  = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: cycle-exact checks at 16 clocks/bit and a
// jittered random byte stream at 17 clocks/bit.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx1   = 1'b1;
    logic       rx2   = 1'b1;
    logic [7:0] data1, data2;
    logic       dv1, dv2, fe1, fe2, busy1, busy2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int dv1_cnt = 0, dv1_last = 0, dv1_prev = 0;
    int fe1_cnt = 0, fe1_last = 0;
    int fe2_cnt = 0, both_cnt = 0;
    int busy_rise = 0, busy_fall = 0;
    logic busy1_prev = 1'b0;
    logic [7:0] got2_q[$];
    logic [7:0] exp2_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .uart_data(data1),
        .data_valid(dv1), .frame_err(fe1), .busy(busy1)
    );

    uart_rx #(.CLKS_PER_BIT(17)) dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .uart_data(data2),
        .data_valid(dv2), .frame_err(fe2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT outputs mid-cycle and log strobe counts and edge times
    always @(negedge clk) begin
        if (dv1) begin
            dv1_cnt  <= dv1_cnt + 1;
            dv1_prev <= dv1_last;
            dv1_last <= cyc;
        end
        if (fe1) begin
            fe1_cnt  <= fe1_cnt + 1;
            fe1_last <= cyc;
        end
        if (busy1 && !busy1_prev) busy_rise <= cyc;
        if (!busy1 && busy1_prev) busy_fall <= cyc;
        busy1_prev <= busy1;
        if (dv2) got2_q.push_back(data2);
        if (fe2) fe2_cnt <= fe2_cnt + 1;
        if ((dv1 && fe1) || (dv2 && fe2)) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drives one frame on rx1 at 16 clocks/bit; leaves the stop level on the line
    task automatic send1(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx1 = bits[i];
            tick(16);
        end
    endtask

    initial begin
        int k;
        int n2;
        int mism;
        logic [9:0] bits;
        logic [7:0] b;
        real bit_ns;

        tick(3);
        check("rst_data", {24'd0, data1}, 32'h00);
        check("rst_dv", {31'd0, dv1}, 32'd0);
        check("rst_fe", {31'd0, fe1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        reset = 1'b0;
        tick(20);

        // single frame 0xA5, cycle-exact latency
        k = cyc + 1;
        send1(8'hA5, 1'b1);
        rx1 = 1'b1;
        tick(20);
        check("a5_count", dv1_cnt, 32'd1);
        check("a5_time", dv1_last, k + 154);
        check("a5_data", {24'd0, data1}, 32'hA5);
        check("a5_fe", fe1_cnt, 32'd0);
        check("a5_busy_rise", busy_rise, k + 2);
        check("a5_busy_fall", busy_fall, k + 154);

        // back-to-back 0x00 then 0xFF with no idle gap
        send1(8'h00, 1'b1);
        check("b2b_first_cnt", dv1_cnt, 32'd2);
        check("b2b_first_data", {24'd0, data1}, 32'h00);
        send1(8'hFF, 1'b1);
        rx1 = 1'b1;
        tick(20);
        check("b2b_second_cnt", dv1_cnt, 32'd3);
        check("b2b_second_data", {24'd0, data1}, 32'hFF);
        check("b2b_spacing", dv1_last - dv1_prev, 32'd160);

        // 3-cycle start glitch is rejected
        rx1 = 1'b0;
        tick(3);
        rx1 = 1'b1;
        tick(40);
        check("glitch_dv", dv1_cnt, 32'd3);
        check("glitch_fe", fe1_cnt, 32'd0);
        check("glitch_data", {24'd0, data1}, 32'hFF);
        check("glitch_busy", {31'd0, busy1}, 32'd0);

        // stop bit low, then line held low as a break
        k = cyc + 1;
        send1(8'h3C, 1'b0);
        tick(100);
        check("brk_fe_cnt", fe1_cnt, 32'd1);
        check("brk_fe_time", fe1_last, k + 154);
        check("brk_busy_rise", busy_rise, k + 2);
        check("brk_busy_held", {31'd0, busy1}, 32'd1);
        check("brk_data", {24'd0, data1}, 32'hFF);
        rx1 = 1'b1;
        n2 = cyc;
        tick(10);
        check("brk_busy_fall", busy_fall, n2 + 3);
        tick(200);
        check("brk_no_dv", dv1_cnt, 32'd3);
        check("brk_no_fe", fe1_cnt, 32'd1);

        // reset midway through data bit 4 of 0x5A
        bits = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx1 = bits[i];
            tick(16);
        end
        rx1 = bits[5];
        tick(8);
        reset = 1'b1;
        rx1   = 1'b1;
        tick(1);
        check("mrst_data", {24'd0, data1}, 32'h00);
        check("mrst_dv", {31'd0, dv1}, 32'd0);
        check("mrst_fe", {31'd0, fe1}, 32'd0);
        check("mrst_busy", {31'd0, busy1}, 32'd0);
        reset = 1'b0;
        tick(200);
        check("mrst_no_dv", dv1_cnt, 32'd3);
        check("mrst_no_fe", fe1_cnt, 32'd1);
        send1(8'h5A, 1'b1);
        rx1 = 1'b1;
        tick(20);
        check("mrst_after_cnt", dv1_cnt, 32'd4);
        check("mrst_after_data", {24'd0, data1}, 32'h5A);

        // 200 random bytes at 17 clocks/bit with +-3% per-frame period jitter
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            exp2_q.push_back(b);
            bit_ns = 170.0 * real'($urandom_range(97, 103)) / 100.0;
            bits = {1'b1, b, 1'b0};
            for (int j = 0; j < 10; j++) begin
                rx2 = bits[j];
                #(bit_ns);
            end
        end
        rx2 = 1'b1;
        for (int t = 0; t < 400 && got2_q.size() < 200; t++) tick(1);
        tick(5);
        check("rnd_count", got2_q.size(), 32'd200);
        mism = 0;
        for (int i = 0; i < 200; i++) begin
            if (i < got2_q.size()) begin
                if (got2_q[i] !== exp2_q[i]) mism++;
            end else begin
                mism++;
            end
        end
        check("rnd_bytes_mismatched", mism, 32'd0);
        check("rnd_fe", fe2_cnt, 32'd0);
        check("dv_fe_exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
